// File: rtl/rv_iopmp_pkg.sv
// rtl/rv_iopmp_pkg.sv - shared IOPMP error-capture record and error-queue state encoding
package rv_iopmp_pkg;

  typedef struct packed {
    logic        error_detected;
    logic [1:0]  ttype;
    logic [15:0] rrid;
    logic [63:0] addr;
  } error_capture_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_SET = 2'd2,
    WAIT_CLR = 2'd3
  } err_queue_state_e;

endpackage

// File: rtl/rv_iopmp_err_fifo.sv
// rtl/rv_iopmp_err_fifo.sv - generic synchronous FIFO with flush and pointer-derived level
module rv_iopmp_err_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  T mem [DEPTH];
  // Extra MSB on each pointer keeps full and empty distinguishable.
  logic [AW:0] wr_ptr_q, rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + LW'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + LW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem[rd_ptr_q[AW-1:0]];
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign full_o  = (level_o == LW'(DEPTH));
  assign empty_o = (level_o == '0);

endmodule

// File: rtl/rv_iopmp_error_queue.sv
// rtl/rv_iopmp_error_queue.sv - buffers IOPMP error events and replays them one at a time into error capture
module rv_iopmp_error_queue
  import rv_iopmp_pkg::*;
#(
  parameter int unsigned NUMBER_IOPMP_INSTANCES = 1,
  parameter int unsigned DEPTH                  = 4,
  parameter int unsigned CNT_W                  = 8
) (
  input  logic                                        clk_i,
  input  logic                                        rst_ni,
  input  error_capture_t [NUMBER_IOPMP_INSTANCES-1:0] err_interface_i,
  output error_capture_t                              err_interface_o,
  input  logic                                        ip_i,
  input  logic                                        ie_i,
  input  logic                                        flush_i,
  input  logic                                        clear_lost_i,
  output logic                                        intr_o,
  output logic                                        lost_o,
  output logic [CNT_W-1:0]                            lost_cnt_o,
  output logic [$clog2(DEPTH):0]                      fifo_level_o
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE    = 2'd1;
  localparam logic [1:0] S_WAIT_SET = 2'd2;
  localparam logic [1:0] S_WAIT_CLR = 2'd3;

  logic [1:0]     state_q, state_d;
  error_capture_t cand, head, out_d;
  logic           cand_valid, extra_drop;
  logic           fifo_full, fifo_empty, push, pop, room, drop;

  always_comb begin
    cand       = '0;
    cand_valid = 1'b0;
    extra_drop = 1'b0;
    for (int i = 0; i < NUMBER_IOPMP_INSTANCES; i++) begin
      if (err_interface_i[i].error_detected) begin
        if (cand_valid) begin
          extra_drop = 1'b1;
        end else begin
          cand_valid = 1'b1;
          cand       = err_interface_i[i];
        end
      end
    end
  end

  // The head is only popped in ISSUE, and ISSUE is only entered with a non-empty FIFO.
  assign pop  = (state_q == S_ISSUE);
  assign room = !fifo_full || pop;
  assign push = cand_valid && room && !flush_i;
  assign drop = !flush_i && (extra_drop || (cand_valid && !room) ||
                             (state_q == S_WAIT_SET && !ip_i));

  rv_iopmp_err_fifo #(
    .T     (error_capture_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (cand),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level_o)
  );

  always_comb begin
    state_d = state_q;
    out_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty && !ip_i) begin
          state_d              = S_ISSUE;
          out_d                = head;
          out_d.error_detected = 1'b1;
        end
      end
      S_ISSUE:    state_d = S_WAIT_SET;
      S_WAIT_SET: state_d = ip_i ? S_WAIT_CLR : S_IDLE;
      default:    if (!ip_i) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      state_q         <= S_IDLE;
      err_interface_o <= '0;
    end else begin
      state_q         <= state_d;
      err_interface_o <= out_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      intr_o     <= 1'b0;
      lost_o     <= 1'b0;
      lost_cnt_o <= '0;
    end else begin
      intr_o <= ip_i & ie_i;
      if (clear_lost_i) begin
        lost_o     <= drop;
        lost_cnt_o <= CNT_W'(drop);
      end else if (drop) begin
        lost_o <= 1'b1;
        if (~&lost_cnt_o) lost_cnt_o <= lost_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv_iopmp_error_queue.sv
// tb/tb_rv_iopmp_error_queue.sv - directed self-checking bench for rv_iopmp_error_queue
module tb_rv_iopmp_error_queue;
  import rv_iopmp_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  error_capture_t [1:0] err_in;
  error_capture_t       err_out;
  logic                 ip, ie, flush, clear_lost;
  logic                 intr, lost;
  logic [7:0]           lost_cnt;
  logic [2:0]           level;

  int n_tests = 0;
  int n_fail  = 0;

  rv_iopmp_error_queue #(
    .NUMBER_IOPMP_INSTANCES (2),
    .DEPTH                  (4),
    .CNT_W                  (8)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .err_interface_i (err_in),
    .err_interface_o (err_out),
    .ip_i            (ip),
    .ie_i            (ie),
    .flush_i         (flush),
    .clear_lost_i    (clear_lost),
    .intr_o          (intr),
    .lost_o          (lost),
    .lost_cnt_o      (lost_cnt),
    .fifo_level_o    (level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic error_capture_t mk(input logic [63:0] addr, input logic [15:0] rrid);
    error_capture_t r;
    r.error_detected = 1'b1;
    r.ttype          = 2'd1;
    r.rrid           = rrid;
    r.addr           = addr;
    return r;
  endfunction

  initial begin
    logic [63:0] b_addr [5];
    for (int k = 0; k < 5; k++) b_addr[k] = 64'h9000_0000 + 64'(k * 64'h100);

    err_in = '0; flush = 0; clear_lost = 0;
    ip = 1; ie = 1; rst_n = 0;
    step(); step();
    chk("rst_out",   128'(err_out),  128'h0);
    chk("rst_intr",  128'(intr),     128'h0);
    chk("rst_lost",  128'(lost),     128'h0);
    chk("rst_cnt",   128'(lost_cnt), 128'h0);
    chk("rst_level", 128'(level),    128'h0);
    rst_n = 1; ip = 0; ie = 0;
    step();

    // Single event, two-cycle latency to the pulse
    err_in[0] = mk(64'h8000_1000, 16'd3);
    step();
    err_in = '0;
    chk("t1_level_push", 128'(level), 128'd1);
    chk("t1_no_pulse_t1", 128'(err_out.error_detected), 128'd0);
    step();
    chk("t1_pulse",  128'(err_out.error_detected), 128'd1);
    chk("t1_addr",   128'(err_out.addr), 128'h8000_1000);
    chk("t1_rrid",   128'(err_out.rrid), 128'd3);
    chk("t1_state_issue", 128'(dut.state_q), 128'(ISSUE));
    step();
    chk("t1_out_zero", 128'(err_out), 128'h0);
    chk("t1_level0",   128'(level),   128'd0);
    ip = 1;
    step();
    chk("t1_wait_clr", 128'(dut.state_q), 128'(WAIT_CLR));
    chk("t1_no_loss",  128'(lost),        128'd0);
    ip = 0;
    step();
    chk("t1_idle", 128'(dut.state_q), 128'(IDLE));

    // Both instances in the same cycle: only instance 0 survives
    err_in[0] = mk(64'h8000_2000, 16'd10);
    err_in[1] = mk(64'h8000_3000, 16'd11);
    step();
    err_in = '0;
    chk("t2_lost",  128'(lost),     128'd1);
    chk("t2_cnt",   128'(lost_cnt), 128'd1);
    chk("t2_level", 128'(level),    128'd1);
    step();
    chk("t2_addr", 128'(err_out.addr), 128'h8000_2000);
    step();
    ip = 1;
    step();
    ip = 0;
    step();
    chk("t2_level_empty", 128'(level), 128'd0);
    clear_lost = 1;
    step();
    clear_lost = 0;
    chk("t2_clr_lost", 128'(lost),     128'd0);
    chk("t2_clr_cnt",  128'(lost_cnt), 128'd0);

    // ip held high: five events into four entries, no replay
    ip = 1;
    for (int k = 0; k < 5; k++) begin
      err_in[0] = mk(b_addr[k], 16'(k));
      step();
      chk("t3_no_pulse_fill", 128'(err_out.error_detected), 128'd0);
    end
    err_in = '0;
    chk("t3_level_full", 128'(level),    128'd4);
    chk("t3_cnt",        128'(lost_cnt), 128'd1);
    clear_lost = 1;
    step();
    clear_lost = 0;
    ip = 0;
    step();
    for (int k = 0; k < 4; k++) begin
      chk("t3_pulse",       128'(err_out.error_detected), 128'd1);
      chk("t3_order",       128'(err_out.addr), 128'(b_addr[k]));
      chk("t3_level_issue", 128'(level), 128'(4 - k));
      step();
      chk("t3_pulse_one_cycle", 128'(err_out.error_detected), 128'd0);
      ip = 1;
      step();
      step();
      ip = 0;
      if (k < 3) begin
        step();
        chk("t3_gap_idle", 128'(err_out.error_detected), 128'd0);
        step();
      end
    end
    step();
    chk("t3_drained", 128'(level),    128'd0);
    chk("t3_no_loss", 128'(lost_cnt), 128'd0);

    // Full FIFO: push coincides with the ISSUE pop
    ip = 1;
    for (int k = 0; k < 4; k++) begin
      err_in[0] = mk(64'hA000_0000 + 64'(k), 16'(k));
      step();
    end
    err_in = '0;
    chk("t4_full", 128'(level), 128'd4);
    ip = 0;
    step();
    chk("t4_issue_addr", 128'(err_out.addr), 128'hA000_0000);
    err_in[0] = mk(64'hA000_0004, 16'd4);
    step();
    err_in = '0;
    chk("t4_level_kept", 128'(level), 128'd4);
    chk("t4_no_loss",    128'(lost),  128'd0);

    // ip not raised in WAIT_SET: counts as lost
    step();
    chk("t5_unaccepted_cnt",  128'(lost_cnt),      128'd1);
    chk("t5_unaccepted_lost", 128'(lost),          128'd1);
    chk("t5_back_idle",       128'(dut.state_q),   128'(IDLE));
    chk("t5_intr_off",        128'(intr),          128'd0);
    ip = 1; ie = 1;
    step();
    chk("t5_intr_on", 128'(intr), 128'd1);

    // Reset in WAIT_CLR with three queued
    ip = 0;
    step();
    step();
    ip = 1;
    step();
    chk("t6_wait_clr", 128'(dut.state_q), 128'(WAIT_CLR));
    chk("t6_level3",   128'(level),       128'd3);
    rst_n = 0;
    step();
    rst_n = 1;
    chk("t6_rst_out",   128'(err_out),     128'h0);
    chk("t6_rst_intr",  128'(intr),        128'd0);
    chk("t6_rst_lost",  128'(lost),        128'd0);
    chk("t6_rst_cnt",   128'(lost_cnt),    128'd0);
    chk("t6_rst_level", 128'(level),       128'd0);
    chk("t6_rst_state", 128'(dut.state_q), 128'(IDLE));
    ie = 0;

    // Flush with two queued and a simultaneous event
    err_in[0] = mk(64'hB000_0000, 16'd0);
    step();
    err_in[0] = mk(64'hB000_0001, 16'd1);
    err_in[1] = mk(64'hB000_0002, 16'd2);
    step();
    chk("t7_level2", 128'(level),    128'd2);
    chk("t7_cnt1",   128'(lost_cnt), 128'd1);
    err_in = '0;
    err_in[0] = mk(64'hB000_0003, 16'd3);
    flush = 1;
    step();
    flush = 0;
    err_in = '0;
    chk("t7_flush_level", 128'(level),    128'd0);
    chk("t7_flush_cnt",   128'(lost_cnt), 128'd1);
    chk("t7_flush_lost",  128'(lost),     128'd1);
    ip = 0;
    step();
    step();
    chk("t7_no_replay", 128'(err_out.error_detected), 128'd0);
    chk("t7_idle",      128'(dut.state_q),            128'(IDLE));

    // Saturation and clear
    ip = 1;
    clear_lost = 1;
    step();
    clear_lost = 0;
    err_in[0] = mk(64'hC000_0000, 16'd0);
    err_in[1] = mk(64'hC000_0001, 16'd1);
    repeat (100) step();
    chk("t8_cnt100", 128'(lost_cnt), 128'd100);
    repeat (200) step();
    chk("t8_sat", 128'(lost_cnt), 128'd255);
    err_in = '0;
    clear_lost = 1;
    step();
    chk("t8_clear_cnt",  128'(lost_cnt), 128'd0);
    chk("t8_clear_lost", 128'(lost),     128'd0);
    err_in[0] = mk(64'hC000_0002, 16'd2);
    err_in[1] = mk(64'hC000_0003, 16'd3);
    step();
    clear_lost = 0;
    err_in = '0;
    chk("t8_clear_drop_cnt",  128'(lost_cnt), 128'd1);
    chk("t8_clear_drop_lost", 128'(lost),     128'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
